// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch program counter with jump/branch redirect, IF/ID flush and halt/resume
module pc_sequencer #(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC    = '0,
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] inc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_next,
    output logic              flush,
    output logic              halted,
    output logic              pc_wrap,
    output logic              align_err
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;
    localparam logic [2:0] FLUSH_LOAD = FLUSH_CYCLES[2:0];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              wrap_q, wrap_d;
    logic              align_q, align_d;
    logic              redirect;
    logic [ADDR_W:0]   sum;

    // Extra top bit captures the carry out for the wrap pulse.
    assign sum = {1'b0, pc_q} + {1'b0, inc};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        wrap_d   = 1'b0;
        align_d  = 1'b0;
        redirect = 1'b0;
        cnt_d    = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;

        if (state_q == ST_RUN) begin
            if (jump) begin
                pc_d     = {jump_target[ADDR_W-1:1], 1'b0};
                align_d  = jump_target[0];
                redirect = 1'b1;
            end else if (branch_taken) begin
                pc_d     = {branch_target[ADDR_W-1:1], 1'b0};
                align_d  = branch_target[0];
                redirect = 1'b1;
            end else if (halt) begin
                state_d = ST_HALT;
            end else begin
                pc_d   = sum[ADDR_W-1:0];
                wrap_d = sum[ADDR_W];
            end
        end else if (resume) begin
            state_d = ST_RUN;
        end

        // A redirect reloads the countdown rather than extending it.
        if (redirect) begin
            cnt_d = FLUSH_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VEC;
            cnt_q   <= 3'd0;
            wrap_q  <= 1'b0;
            align_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            align_q <= align_d;
        end
    end

    assign pc_out    = pc_q;
    assign pc_next   = sum[ADDR_W-1:0];
    assign flush     = (cnt_q != 3'd0);
    assign halted    = (state_q == ST_HALT);
    assign pc_wrap   = wrap_q;
    assign align_err = align_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a behavioural model
module tb_pc_sequencer;

    localparam int FLUSH_N = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] inc = '0;
    logic        jump = 1'b0;
    logic [15:0] jump_target = '0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic [15:0] pc_out;
    logic [15:0] pc_next;
    logic        flush;
    logic        halted;
    logic        pc_wrap;
    logic        align_err;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model state
    int m_pc;
    bit m_halted;
    int m_flush_left;
    bit m_wrap;
    bit m_align;

    pc_sequencer #(
        .ADDR_W(16),
        .RESET_VEC(16'h0000),
        .FLUSH_CYCLES(FLUSH_N)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .inc(inc),
        .jump(jump),
        .jump_target(jump_target),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .halt(halt),
        .resume(resume),
        .pc_out(pc_out),
        .pc_next(pc_next),
        .flush(flush),
        .halted(halted),
        .pc_wrap(pc_wrap),
        .align_err(align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_halted = 0;
        m_flush_left = 0;
        m_wrap = 0;
        m_align = 0;
    endtask

    task automatic model_edge();
        int  tgt;
        bit  redir;
        redir = 0;
        m_wrap = 0;
        m_align = 0;
        if (!m_halted) begin
            if (jump || branch_taken) begin
                tgt = jump ? int'(jump_target) : int'(branch_target);
                m_align = (tgt % 2) == 1;
                m_pc = tgt - (tgt % 2);
                redir = 1;
            end else if (halt) begin
                m_halted = 1;
            end else begin
                m_pc = m_pc + int'(inc);
                m_wrap = m_pc >= 65536;
                m_pc = m_pc % 65536;
            end
        end else if (resume) begin
            m_halted = 0;
        end
        if (redir) m_flush_left = FLUSH_N;
        else if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
    endtask

    task automatic check_outputs(input string phase);
        chk({phase, ".pc_out"}, 32'(pc_out), 32'(m_pc));
        chk({phase, ".flush"}, 32'(flush), 32'(m_flush_left != 0));
        chk({phase, ".halted"}, 32'(halted), 32'(m_halted));
        chk({phase, ".pc_wrap"}, 32'(pc_wrap), 32'(m_wrap));
        chk({phase, ".align_err"}, 32'(align_err), 32'(m_align));
    endtask

    task automatic step(input string phase, input logic j, input logic [15:0] jt,
                        input logic b, input logic [15:0] bt, input logic h,
                        input logic r, input logic [15:0] i);
        jump = j;
        jump_target = jt;
        branch_taken = b;
        branch_target = bt;
        halt = h;
        resume = r;
        inc = i;
        #1;
        chk({phase, ".pc_next"}, 32'(pc_next), 32'((m_pc + int'(i)) % 65536));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(phase);
    endtask

    task automatic run_inc(input string phase, input int n, input logic [15:0] i);
        for (int k = 0; k < n; k++) step(phase, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, i);
    endtask

    task automatic async_reset(input string phase);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(phase);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.pc_const", 32'(pc_out), 32'h0000);
        rst_n = 1'b1;

        // Plain fetch
        run_inc("t1_fetch", 4, 16'h0002);
        chk("t1.pc_0008", 32'(pc_out), 32'h0008);
        run_inc("t1_fetch", 4, 16'h0002);

        // Stall holds PC
        run_inc("t2_stall", 3, 16'h0000);
        chk("t2.pc_hold", 32'(pc_out), 32'h0010);
        run_inc("t2_run", 1, 16'h0002);
        chk("t2.pc_0012", 32'(pc_out), 32'h0012);
        run_inc("t2_run", 7, 16'h0002);
        chk("t3.pc_0020", 32'(pc_out), 32'h0020);

        // Jump beats branch
        step("t3_redirect", 1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0, 1'b0, 16'h0002);
        chk("t3.pc_0100", 32'(pc_out), 32'h0100);
        run_inc("t3_flush", 3, 16'h0002);

        // Misaligned branch then back-to-back branch
        step("t4_br1", 1'b0, 16'h0, 1'b1, 16'h0301, 1'b0, 1'b0, 16'h0002);
        chk("t4.align_pulse", 32'(align_err), 32'h1);
        step("t4_br2", 1'b0, 16'h0, 1'b1, 16'h0400, 1'b0, 1'b0, 16'h0002);
        chk("t4.pc_0400", 32'(pc_out), 32'h0400);
        run_inc("t4_flush", 3, 16'h0002);

        // Wrap at top of address space
        step("t5_jump", 1'b1, 16'hFFFC, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0000);
        run_inc("t5_settle", 2, 16'h0000);
        run_inc("t5_wrap", 2, 16'h0002);
        chk("t5.wrap_pulse", 32'(pc_wrap), 32'h1);
        chk("t5.pc_0000", 32'(pc_out), 32'h0000);
        run_inc("t5_after", 1, 16'h0002);

        // Halt, ignored jump, resume
        step("t6_jump", 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0000);
        run_inc("t6_settle", 2, 16'h0000);
        step("t6_halt", 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0002);
        step("t6_hold", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0002);
        step("t6_jmp_ign", 1'b1, 16'h0800, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0002);
        step("t6_hold", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0002);
        chk("t6.pc_frozen", 32'(pc_out), 32'h0040);
        chk("t6.halted", 32'(halted), 32'h1);
        step("t6_resume", 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0002);
        run_inc("t6_run", 1, 16'h0002);
        chk("t6.pc_0042", 32'(pc_out), 32'h0042);

        // Asynchronous reset while halted
        step("t6b_halt", 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0002);
        step("t6b_hold", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0002);
        async_reset("t6b_reset");
        chk("t6b.halted_clr", 32'(halted), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic        rj, rb, rh, rr;
            logic [15:0] rjt, rbt, ri;
            rj  = ($urandom_range(0, 7) == 0);
            rb  = ($urandom_range(0, 5) == 0);
            rh  = ($urandom_range(0, 9) == 0);
            rr  = ($urandom_range(0, 3) == 0);
            rjt = 16'($urandom);
            rbt = 16'($urandom);
            case ($urandom_range(0, 9))
                0, 1:    ri = 16'h0000;
                2:       ri = 16'($urandom_range(0, 15));
                default: ri = 16'h0002;
            endcase
            step("rand", rj, rjt, rb, rbt, rh, rr, ri);
            if ($urandom_range(0, 63) == 0) async_reset("rand_reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the next-address mux.
- Consumes the 16-bit increment from the mux: 2 for normal fetch, 0 for a stall.
- Holds the architectural fetch PC and applies jump and branch redirects.
- Drives a multi-cycle IF/ID flush after each redirect and implements halt/resume, so the fetch front end sees one authoritative address per cycle.

Parameters:
- ADDR_W, 16: PC and target width.
- RESET_VEC, 16'h0000: PC value loaded on reset.
- FLUSH_CYCLES, 2: cycles flush stays high after a redirect; legal 1..7.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inc  in  ADDR_W  increment from the next-address mux (16'h0002 run, 16'h0000 stall).
- jump  in  1  unconditional redirect request.
- jump_target  in  ADDR_W  jump destination.
- branch_taken  in  1  resolved taken branch.
- branch_target  in  ADDR_W  branch destination.
- halt  in  1  request to freeze fetch.
- resume  in  1  request to leave HALT.
- pc_out  out  ADDR_W  current fetch address (registered).
- pc_next  out  ADDR_W  combinational pc_out + inc, modulo 2^ADDR_W.
- flush  out  1  kill IF/ID contents; registered.
- halted  out  1  high while in HALT state; registered.
- pc_wrap  out  1  one-cycle pulse when an increment wraps past the top of the address space.
- align_err  out  1  one-cycle pulse when an accepted redirect target has bit0 = 1.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-flush or HALT):
  - pc_out = RESET_VEC, flush = 0, halted = 0, pc_wrap = 0, align_err = 0.
  - Flush counter = 0, state = RUN.
  - After release, the first rising edge behaves as RUN.
- State machine, two states:
  - RUN → HALT when halt = 1 and no redirect that cycle.
  - HALT → RUN when resume = 1.
  - halt and resume both high in HALT: resume wins.
- Priority in RUN each cycle: jump > branch_taken > halt > increment.
- Jump or branch in RUN:
  - pc_out <= target with bit0 forced to 0.
  - align_err <= original target bit0.
  - Flush counter <= FLUSH_CYCLES.
  - A redirect while the counter is nonzero reloads it; it does not add.
- Increment in RUN:
  - pc_out <= pc_out + inc, truncated to ADDR_W.
  - pc_wrap <= 1 iff the carry out of the add is 1.
  - inc = 0 holds the PC; flush countdown continues during a stall.
- HALT state:
  - pc_out holds; jump, branch and inc are ignored.
  - halted = 1 from the cycle after entry until the cycle after resume.
  - The flush counter keeps decrementing.
- flush = 1 whenever the flush counter is nonzero.
  - The counter decrements by 1 per cycle to 0.
  - flush asserts the cycle after the redirect edge and lasts exactly FLUSH_CYCLES cycles with no further redirects.
- pc_wrap and align_err are single-cycle pulses; they return to 0 the next cycle unless the condition recurs.
- inc with bit0 = 1 is a protocol violation; the result is still computed as a plain add (no masking).
- Latency:
  - Redirect target visible on pc_out one cycle after the request.
  - Halt freezes pc_out from the same edge that samples halt.

Test Plan:
1. Reset, then inc = 2 for 4 cycles → pc_out 0000, 0002, 0004, 0006, 0008; flush, halted, pc_wrap all 0.
2. At pc_out = 0010, inc = 0 for 3 cycles, then inc = 2 → pc_out holds 0010 for 3 cycles, then 0012.
3. At pc_out = 0020, jump = 1 with jump_target = 0100 and branch_taken = 1 with branch_target = 0200 in the same cycle → next pc_out = 0100, flush high exactly 2 cycles, align_err 0.
4. branch_target = 0301 taken, then a second branch to 0400 one cycle later → pc_out 0300 with align_err pulse, then 0400; flush stays high 2 cycles after the second redirect (3 total).
5. pc_out = FFFC, inc = 2 → FFFE, then 0000 with a pc_wrap pulse on that cycle only.
6. halt at pc_out = 0040 with inc = 2 for 3 cycles, jump asserted mid-halt, then resume:
   - pc_out stays 0040 and halted = 1; the jump is ignored.
   - After resume, pc_out = 0042.
   - Assert rst_n low mid-halt in a second run → pc_out = 0000, halted = 0 immediately.
